ahb_master_arbiter: RTL

//  Round-robin arbiter that drives the HMSEL select of the 4-port AHB master mux.

---
 rtl/ahb_master_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/ahb_master_arbiter.sv
// Round-robin owner select for the 4-port AHB master mux. The owner changes only
// on HREADY beats with no owner lock held, so the mux's select pipeline stays stable.
module ahb_master_arbiter #(
    parameter logic [3:0] M_ENABLE     = 4'b1111,
    parameter int         PARK_MASTER  = 0,
    parameter bit         PARK_ON_IDLE = 1'b1,
    parameter int         MAX_HOLD     = 16,
    parameter int         CW           = 5
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [3:0] REQ,
    input  logic [3:0] LOCK,
    output logic [1:0] HMSEL,
    output logic [3:0] GRANT,
    output logic       OWNED
);

    typedef enum logic {PARK = 1'b0, OWN = 1'b1} state_e;

    localparam logic [1:0]    PARK_SEL = PARK_MASTER[1:0];
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] EXP_TH   = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    rr_q, rr_d;
    logic [3:0]    grant_q, grant_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [3:0] ereq;
    logic [1:0] win, idx;
    logic       lock_cur, others, expired, sw;

    assign ereq = REQ & M_ENABLE;

    // Scan from the far end so the nearest requester after rr_q is the last
    // assignment; k=4 lands on rr_q itself, which is therefore considered last.
    always_comb begin
        win = rr_q;
        idx = rr_q;
        for (int k = 4; k >= 1; k--) begin
            idx = rr_q + 2'(k);
            if (ereq[idx]) win = idx;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        hold_d   = hold_q;
        lock_cur = LOCK[sel_q] & M_ENABLE[sel_q];
        others   = |(ereq & ~grant_q);
        expired  = (MAX_HOLD != 0) && (hold_q >= EXP_TH);
        sw       = !lock_cur && (!ereq[sel_q] || (expired && others));

        if (HREADY) begin
            case (state_q)
                PARK: begin
                    if (ereq != 4'b0) begin
                        sel_d   = win;
                        rr_d    = win;
                        hold_d  = '0;
                        state_d = OWN;
                    end
                end
                OWN: begin
                    if (!sw) begin
                        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
                    end else if (others) begin
                        sel_d  = win;
                        rr_d   = win;
                        hold_d = '0;
                    end else if (ereq[sel_q]) begin
                        hold_d = '0;
                    end else begin
                        state_d = PARK;
                        hold_d  = '0;
                        if (PARK_ON_IDLE) sel_d = PARK_SEL;
                    end
                end
                default: state_d = PARK;
            endcase
        end

        grant_d = 4'b0001 << sel_d;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= PARK;
            sel_q   <= PARK_SEL;
            rr_q    <= PARK_SEL;
            grant_q <= 4'b0001 << PARK_SEL;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
        end
    end

    assign HMSEL = sel_q;
    assign GRANT = grant_q;
    assign OWNED = (state_q == OWN);

endmodule
